// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller: merges stage stall requests, multi-cycle
// EX ops and MEM exceptions into a stall vector plus a PC redirect.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VEC = 32'h0000_0020,
    parameter int          LEN_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             br_req,
    input  logic [31:0]      br_target,
    input  logic             mcyc_start,
    input  logic [LEN_W-1:0] mcyc_len,
    input  logic             exc_req,
    input  logic [31:0]      exc_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic             br,
    output logic [31:0]      br_addr,
    output logic             mcyc_done,
    output logic [31:0]      epc
);

    typedef enum logic [1:0] {RUN, MCYC, EXC} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic [31:0]      epc_q, epc_d;

    logic [5:0] req_stall;
    logic       mcyc_go;
    logic       mstall;

    // A request from stage s holds every stage from the PC up to s.
    assign req_stall = {1'b0,
                        stallreq_mem,
                        stallreq_ex | stallreq_mem,
                        stallreq_id | stallreq_ex | stallreq_mem,
                        stallreq_if | stallreq_id | stallreq_ex | stallreq_mem,
                        stallreq_if | stallreq_id | stallreq_ex | stallreq_mem};

    assign mcyc_go = (state_q == RUN) && mcyc_start && (mcyc_len != '0);
    assign mstall  = (state_q == MCYC) || mcyc_go;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        epc_d       = epc_q;
        stall       = '0;
        flush       = 1'b0;
        br          = 1'b0;
        br_addr     = '0;
        mcyc_done   = 1'b0;

        if (rst) begin
            state_d  = RUN;
            cnt_d    = '0;
            pend_v_d = 1'b0;
            epc_d    = '0;
        end else if (state_q == EXC) begin
            flush   = 1'b1;
            br      = 1'b1;
            br_addr = EXC_VEC;
            if (exc_req) begin
                epc_d   = exc_pc;
                state_d = EXC;
            end else begin
                state_d = RUN;
            end
        end else begin
            stall = req_stall | {2'b00, {4{mstall}}};
            if (exc_req) begin
                // Exception aborts any multi-cycle op and drops a pending redirect.
                epc_d    = exc_pc;
                state_d  = EXC;
                cnt_d    = '0;
                pend_v_d = 1'b0;
            end else begin
                if (state_q == MCYC) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        mcyc_done = 1'b1;
                        state_d   = RUN;
                    end
                end else if (mcyc_go) begin
                    if (mcyc_len == LEN_W'(1)) begin
                        mcyc_done = 1'b1;
                    end else begin
                        cnt_d   = mcyc_len - LEN_W'(1);
                        state_d = MCYC;
                    end
                end

                if (stall[0]) begin
                    if (br_req) begin
                        pend_v_d    = 1'b1;
                        pend_addr_d = br_target;
                    end
                end else if (br_req) begin
                    br       = 1'b1;
                    br_addr  = br_target;
                    pend_v_d = 1'b0;
                end else if (pend_v_q) begin
                    br       = 1'b1;
                    br_addr  = pend_addr_q;
                    pend_v_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            epc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            epc_q       <= epc_d;
        end
    end

    assign epc = rst ? '0 : epc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a cycle-level model.
module tb_pipe_ctrl;
    localparam logic [31:0] EXC_VEC = 32'h0000_0020;
    localparam int          LEN_W   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic             br_req;
    logic [31:0]      br_target;
    logic             mcyc_start;
    logic [LEN_W-1:0] mcyc_len;
    logic             exc_req;
    logic [31:0]      exc_pc;
    logic [5:0]       stall;
    logic             flush, br, mcyc_done;
    logic [31:0]      br_addr, epc;

    pipe_ctrl #(.EXC_VEC(EXC_VEC), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .br_req(br_req), .br_target(br_target),
        .mcyc_start(mcyc_start), .mcyc_len(mcyc_len),
        .exc_req(exc_req), .exc_pc(exc_pc),
        .stall(stall), .flush(flush), .br(br), .br_addr(br_addr),
        .mcyc_done(mcyc_done), .epc(epc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: stall cycles still owed to a multi-cycle op, exception flag, pending redirect.
    int          m_rem  = 0;
    bit          m_exc  = 0;
    bit          m_pv   = 0;
    logic [31:0] m_pa   = '0;
    logic [31:0] m_epc  = '0;
    int          m_left = 0;

    logic [5:0]  e_stall;
    logic        e_flush, e_br, e_done;
    logic [31:0] e_addr, e_epc;
    logic [72:0] got, exp_v;

    function automatic void model_eval();
        logic [4:1] rq;
        e_stall = '0; e_flush = 0; e_br = 0; e_done = 0; e_addr = '0; e_epc = '0;
        m_left = 0;
        if (rst) return;
        e_epc = m_epc;
        if (m_exc) begin
            e_flush = 1; e_br = 1; e_addr = EXC_VEC;
            return;
        end
        if (m_rem > 0) m_left = m_rem;
        else if (mcyc_start && mcyc_len != 0) m_left = int'(mcyc_len);
        rq = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
        for (int s = 1; s <= 4; s++)
            if (rq[s]) for (int j = 0; j <= s; j++) e_stall[j] = 1'b1;
        if (m_left > 0) e_stall[3:0] = 4'hF;
        if (exc_req) return;
        e_done = (m_left == 1);
        if (!e_stall[0]) begin
            if (br_req) begin e_br = 1; e_addr = br_target; end
            else if (m_pv) begin e_br = 1; e_addr = m_pa; end
        end
    endfunction

    function automatic void model_update();
        if (rst) begin
            m_rem = 0; m_exc = 0; m_pv = 0; m_epc = '0;
            return;
        end
        if (m_exc) begin
            m_exc = exc_req;
            if (exc_req) m_epc = exc_pc;
            return;
        end
        if (exc_req) begin
            m_exc = 1; m_epc = exc_pc; m_rem = 0; m_pv = 0;
            return;
        end
        m_rem = (m_left > 0) ? m_left - 1 : 0;
        if (e_stall[0]) begin
            if (br_req) begin m_pv = 1; m_pa = br_target; end
        end else begin
            m_pv = 0;
        end
    endfunction

    task automatic clr_in();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        br_req = 0; br_target = '0; mcyc_start = 0; mcyc_len = '0;
        exc_req = 0; exc_pc = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        got   = {stall, flush, br, br_addr, mcyc_done, epc};
        exp_v = {e_stall, e_flush, e_br, e_addr, e_done, e_epc};
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1; stallreq_ex = 1; br_req = 1; br_target = 32'h55; mcyc_start = 1; mcyc_len = 3;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (got !== 73'd0) begin
                bad++; $display("FAIL reset c%0d got=%h exp=0", i, got);
            end
            adv();
        end
        rst = 0; clr_in();
        settle();
        total++;
        if (got !== exp_v) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, exp_v); end
        adv();
    endtask

    task automatic test_stage_stall();
        clr_in(); stallreq_ex = 1;
        settle();
        total++;
        if (stall !== 6'b001111 || got !== exp_v) begin
            bad++; $display("FAIL stage_stall_ex got=%b exp=001111", stall);
        end
        adv();
        clr_in();
        settle();
        total++;
        if (stall !== 6'b000000) begin bad++; $display("FAIL stage_stall_clear got=%b exp=0", stall); end
        adv();
        stallreq_mem = 1;
        settle();
        total++;
        if (stall !== 6'b011111) begin bad++; $display("FAIL stage_stall_mem got=%b exp=011111", stall); end
        adv();
        clr_in();
    endtask

    task automatic test_mcyc();
        clr_in(); mcyc_start = 1; mcyc_len = 4;
        for (int i = 0; i < 6; i++) begin
            settle();
            total++;
            if (got !== exp_v || mcyc_done !== (i == 3) || stall[3:0] !== ((i < 4) ? 4'hF : 4'h0)) begin
                bad++; $display("FAIL mcyc_len4 c%0d got=%h exp=%h", i, got, exp_v);
            end
            adv();
            clr_in();
            // start while busy must be ignored
            if (i == 1) begin mcyc_start = 1; mcyc_len = 9; end
        end
    endtask

    task automatic test_branch_pending();
        clr_in(); stallreq_id = 1; br_req = 1; br_target = 32'h100;
        for (int i = 0; i < 5; i++) begin
            settle();
            total++;
            if (got !== exp_v || br !== (i == 3) || (i == 3 && br_addr !== 32'h100)) begin
                bad++; $display("FAIL branch_pend c%0d got=%h exp=%h", i, got, exp_v);
            end
            adv();
            br_req = 0;
            if (i == 1) begin br_req = 1; br_target = 32'h100; end
            if (i >= 1) stallreq_id = 0;
            if (i < 1) stallreq_id = 1;
            if (i == 1) stallreq_id = 1;
        end
        clr_in();
    endtask

    task automatic test_exception();
        clr_in(); mcyc_start = 1; mcyc_len = 8;
        for (int i = 0; i < 6; i++) begin
            settle();
            total++;
            if (got !== exp_v || mcyc_done !== 1'b0) begin
                bad++; $display("FAIL exc c%0d got=%h exp=%h", i, got, exp_v);
            end
            if (i == 3) begin
                total++;
                if ({flush, br, br_addr, stall, epc} !== {1'b1, 1'b1, EXC_VEC, 6'b0, 32'h44}) begin
                    bad++; $display("FAIL exc_redirect got fl=%b br=%b addr=%h st=%b epc=%h exp 1 1 %h 0 44",
                                    flush, br, br_addr, stall, epc, EXC_VEC);
                end
            end
            adv();
            clr_in();
            if (i == 1) begin exc_req = 1; exc_pc = 32'h44; end
        end
    endtask

    task automatic test_rst_mid();
        clr_in(); mcyc_start = 1; mcyc_len = 5;
        for (int i = 0; i < 6; i++) begin
            settle();
            total++;
            if (got !== exp_v || (i >= 1 && (stall !== 6'b0 || mcyc_done !== 1'b0))) begin
                bad++; $display("FAIL rst_mid c%0d got=%h exp=%h", i, got, exp_v);
            end
            adv();
            clr_in();
            rst = (i == 0);
        end
        rst = 0;
    endtask

    task automatic test_mcyc_len_edge();
        clr_in(); mcyc_start = 1; mcyc_len = 0;
        settle();
        total++;
        if (stall !== 6'b0 || mcyc_done !== 1'b0) begin
            bad++; $display("FAIL mcyc_len0 got st=%b done=%b exp 0 0", stall, mcyc_done);
        end
        adv();
        mcyc_len = 1;
        settle();
        total++;
        if (stall !== 6'b001111 || mcyc_done !== 1'b1) begin
            bad++; $display("FAIL mcyc_len1 got st=%b done=%b exp 001111 1", stall, mcyc_done);
        end
        adv();
        clr_in();
        settle();
        total++;
        if (stall !== 6'b0 || mcyc_done !== 1'b0) begin
            bad++; $display("FAIL mcyc_len1_after got st=%b done=%b exp 0 0", stall, mcyc_done);
        end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            stallreq_if  = ($urandom_range(0, 99) < 8);
            stallreq_id  = ($urandom_range(0, 99) < 8);
            stallreq_ex  = ($urandom_range(0, 99) < 8);
            stallreq_mem = ($urandom_range(0, 99) < 8);
            br_req       = ($urandom_range(0, 99) < 25);
            br_target    = $urandom;
            mcyc_start   = ($urandom_range(0, 99) < 12);
            mcyc_len     = LEN_W'($urandom_range(0, 7));
            exc_req      = ($urandom_range(0, 99) < 4);
            exc_pc       = $urandom;
            settle();
            total++;
            if (got !== exp_v) begin
                bad++; $display("FAIL random c%0d got=%h exp=%h", i, got, exp_v);
            end
            adv();
        end
        rst = 0; clr_in();
    endtask

    initial begin
        rst = 1;
        clr_in();
        @(posedge clk); #1;
        test_reset();
        test_stage_stall();
        test_mcyc();
        test_branch_pending();
        test_exception();
        test_rst_mid();
        test_mcyc_len_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
